// File: rtl/data_mem_master_if.sv
// Bundles the request, write-data, read-data, status and data_mem strobe
// signals of the data-memory initiator port.
interface data_mem_master_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int LEN_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;

  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;

  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_last;

  logic              busy;
  logic              done;

  logic              sig_mem_read;
  logic              sig_mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  // The initiator itself.
  modport master (
    input  req_valid, req_write, req_addr, req_len,
    input  wdata_valid, wdata,
    input  rdata_ready,
    input  mem_read_data,
    output req_ready, wdata_ready,
    output rdata_valid, rdata, rdata_last,
    output busy, done,
    output sig_mem_read, sig_mem_write, mem_addr, mem_write_data
  );

  // Load/store stage plus data_mem on the far side.
  modport slave (
    output req_valid, req_write, req_addr, req_len,
    output wdata_valid, wdata,
    output rdata_ready,
    output mem_read_data,
    input  req_ready, wdata_ready,
    input  rdata_valid, rdata, rdata_last,
    input  busy, done,
    input  sig_mem_read, sig_mem_write, mem_addr, mem_write_data
  );
endinterface

// File: rtl/data_mem_master.sv
// Data-memory initiator: turns single/burst read and write requests into
// one data_mem strobe per cycle and returns read beats on a registered stream.
module data_mem_master #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beat;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_valid;
  logic              r_rdata_last;
  logic              r_done;
  logic              r_busy;
  logic              r_req_ready;
  logic              r_wdata_ready;

  logic              w_slot_free;
  logic              w_rd_issue;
  logic              w_wr_beat;
  logic              w_last_beat;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [LEN_W-1:0]  w_beat_inc;

  // A read may only issue when the output register is empty or being drained.
  assign w_slot_free = !r_rdata_valid || bus.rdata_ready;
  assign w_rd_issue  = !rst && (r_state == S_RD) && w_slot_free;
  assign w_wr_beat   = !rst && (r_state == S_WR) && bus.wdata_valid;
  assign w_last_beat = (r_beat == r_len);
  assign w_addr_inc  = r_addr + ADDR_W'(1);
  assign w_beat_inc  = r_beat + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_rdata_last  <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_req_ready   <= 1'b1;
      r_wdata_ready <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Output stream runs independently of the state so a trailing beat
      // can still drain in DONE/IDLE or during the next request.
      if (w_rd_issue) begin
        r_rdata       <= bus.mem_read_data;
        r_rdata_valid <= 1'b1;
        r_rdata_last  <= w_last_beat;
      end else if (r_rdata_valid && bus.rdata_ready) begin
        r_rdata_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_addr      <= bus.req_addr;
            r_len       <= bus.req_len;
            r_beat      <= '0;
            r_busy      <= 1'b1;
            r_req_ready <= 1'b0;
            if (bus.req_write) begin
              r_state       <= S_WR;
              r_wdata_ready <= 1'b1;
            end else begin
              r_state <= S_RD;
            end
          end
        end

        S_RD: begin
          if (w_rd_issue) begin
            r_addr <= w_addr_inc;
            r_beat <= w_beat_inc;
            if (w_last_beat) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        S_WR: begin
          if (w_wr_beat) begin
            r_addr <= w_addr_inc;
            r_beat <= w_beat_inc;
            if (w_last_beat) begin
              r_state       <= S_DONE;
              r_done        <= 1'b1;
              r_wdata_ready <= 1'b0;
            end
          end
        end

        S_DONE: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
        end

        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.wdata_ready    = r_wdata_ready;
  assign bus.rdata_valid    = r_rdata_valid;
  assign bus.rdata          = r_rdata;
  assign bus.rdata_last     = r_rdata_last;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;

  // Address and write data are forced to zero whenever no strobe is active.
  assign bus.sig_mem_read   = w_rd_issue;
  assign bus.sig_mem_write  = w_wr_beat;
  assign bus.mem_addr       = (w_rd_issue || w_wr_beat) ? r_addr : '0;
  assign bus.mem_write_data = w_wr_beat ? bus.wdata : '0;

endmodule

// File: tb/tb_data_mem_master.sv
// Directed plus randomized bench for data_mem_master against an array-based
// memory reference and burst-level expectations.
module tb_data_mem_master;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int LEN_W  = 3;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_load = 1'b1;

  always #5 clk = ~clk;

  data_mem_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  data_mem_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] init_vals [DEPTH];
  logic [15:0] mem       [DEPTH];
  logic [15:0] ref_mem   [DEPTH];

  int n_vec = 0;
  int n_err = 0;
  logic prev_done = 1'b0;

  // Stand-in for data_mem: combinational read, write at the strobed edge.
  assign bus.mem_read_data = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_vals[i];
    end else if (bus.sig_mem_write) begin
      mem[bus.mem_addr] <= bus.mem_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    n_vec++;
    assert (!(bus.sig_mem_read && bus.sig_mem_write)) else begin
      n_err++;
      $error("FAIL strobe_excl: observed rd=%b wr=%b expected not both", bus.sig_mem_read, bus.sig_mem_write);
    end
    n_vec++;
    assert (!(bus.done && prev_done)) else begin
      n_err++;
      $error("FAIL done_pulse: observed done high 2 cycles expected 1");
    end
    prev_done = bus.done;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic wr, input int addr, input int len);
    int waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      cyc();
      waited++;
    end
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = 3'(addr);
    bus.req_len   = 3'(len);
    cyc();
    // Fields are scrambled after acceptance; the DUT must ignore them.
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = 3'($urandom);
    bus.req_len   = 3'($urandom);
  endtask

  task automatic do_read(input int addr, input int len, input int stall_pct,
                         input int first_stall, output int cycles);
    int L = len + 1;
    int k = 0;
    int strobes = 0;
    int cyc_n = 0;
    int stall_left = -1;
    bit prev_final = 1'b0;
    bit done_seen = 1'b0;
    bit was_stalled = 1'b0;
    bit exp_rd;
    logic [15:0] held = '0;
    logic [15:0] exp_q [$];
    for (int i = 0; i < L; i++) exp_q.push_back(ref_mem[3'((addr + i) % DEPTH)]);
    send_req(1'b0, addr, len);
    while ((k < L || !done_seen) && cyc_n < 200) begin
      if (k == 0 && bus.rdata_valid === 1'b1 && stall_left < 0) stall_left = first_stall;
      if (stall_left > 0) begin
        bus.rdata_ready = 1'b0;
        stall_left--;
      end else begin
        bus.rdata_ready = ($urandom_range(99) >= stall_pct);
      end
      #1;
      exp_rd = (strobes < L) && (!bus.rdata_valid || bus.rdata_ready);
      chk("rd_strobe", 32'(bus.sig_mem_read), 32'(exp_rd));
      chk("rd_addr", 32'(bus.mem_addr), exp_rd ? 32'((addr + strobes) % DEPTH) : 32'd0);
      chk("rd_no_wr", 32'(bus.sig_mem_write), 32'd0);
      chk("rd_done", 32'(bus.done), 32'(prev_final));
      if (was_stalled) chk("rd_hold", 32'(bus.rdata), 32'(held));
      if (k >= L) chk("rd_extra_beat", 32'(bus.rdata_valid), 32'd0);
      if (bus.rdata_valid === 1'b1 && bus.rdata_ready && k < L) begin
        chk("rd_data", 32'(bus.rdata), 32'(exp_q[k]));
        chk("rd_last", 32'(bus.rdata_last), 32'(k == L - 1));
        k++;
      end
      if (bus.done === 1'b1) done_seen = 1'b1;
      was_stalled = (bus.rdata_valid === 1'b1) && !bus.rdata_ready;
      held = bus.rdata;
      prev_final = exp_rd && (strobes == L - 1);
      if (exp_rd) strobes++;
      cyc();
      cyc_n++;
    end
    chk("rd_timeout", 32'(cyc_n < 200), 32'd1);
    bus.rdata_ready = 1'b1;
    cycles = cyc_n;
  endtask

  task automatic do_write(input int addr, input int len, input logic [15:0] vals [8],
                          input int gap_pct, input int first_gap, output int cycles);
    int L = len + 1;
    int k = 0;
    int cyc_n = 0;
    int gap_left = -1;
    bit prev_final = 1'b0;
    bit done_seen = 1'b0;
    bit v;
    send_req(1'b1, addr, len);
    while ((k < L || !done_seen) && cyc_n < 200) begin
      if (k == 1 && gap_left < 0) gap_left = first_gap;
      if (k >= L) begin
        v = 1'b0;
      end else if (gap_left > 0) begin
        v = 1'b0;
        gap_left--;
      end else begin
        v = ($urandom_range(99) >= gap_pct);
      end
      bus.wdata_valid = v;
      bus.wdata = v ? vals[k] : 16'($urandom);
      #1;
      chk("wr_strobe", 32'(bus.sig_mem_write), 32'(v));
      chk("wr_no_rd", 32'(bus.sig_mem_read), 32'd0);
      chk("wr_addr", 32'(bus.mem_addr), v ? 32'((addr + k) % DEPTH) : 32'd0);
      chk("wr_data", 32'(bus.mem_write_data), v ? 32'(vals[k]) : 32'd0);
      chk("wr_done", 32'(bus.done), 32'(prev_final));
      if (k < L) begin
        chk("wr_ready", 32'(bus.wdata_ready), 32'd1);
        chk("wr_busy", 32'(bus.busy), 32'd1);
      end
      prev_final = v && (k == L - 1);
      if (v) begin
        ref_mem[3'((addr + k) % DEPTH)] = vals[k];
        k++;
      end
      if (bus.done === 1'b1) done_seen = 1'b1;
      cyc();
      cyc_n++;
    end
    chk("wr_timeout", 32'(cyc_n < 200), 32'd1);
    bus.wdata_valid = 1'b0;
    cycles = cyc_n;
  endtask

  initial begin
    logic [15:0] vals [8];
    int cycles;

    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    bus.rdata_ready = 1'b1;

    init_vals[0] = 16'h0045;
    init_vals[1] = 16'h0006;
    init_vals[2] = 16'h0009;
    for (int i = 3; i < DEPTH; i++) init_vals[i] = 16'($urandom);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_vals[i];

    // Reset state
    rst = 1'b1;
    mem_load = 1'b1;
    repeat (3) cyc();
    chk("rst_rdata_valid", 32'(bus.rdata_valid), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_rdata_last", 32'(bus.rdata_last), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_strobes", 32'({bus.sig_mem_read, bus.sig_mem_write}), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    mem_load = 1'b0;
    cyc();

    // 1: read 0 len 2, back-to-back beats
    do_read(0, 2, 0, 0, cycles);
    chk("t1_cycles", 32'(cycles), 32'd4);

    // 2: wrapping write then read back
    vals = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4, 16'h0, 16'h0, 16'h0, 16'h0};
    do_write(6, 3, vals, 0, 0, cycles);
    chk("t2_wr_cycles", 32'(cycles), 32'd5);
    do_read(6, 3, 0, 0, cycles);
    chk("t2_rd_cycles", 32'(cycles), 32'd5);

    // 3: stall three cycles on the first read beat
    do_read(0, 2, 0, 3, cycles);
    chk("t3_cycles", 32'(cycles), 32'd7);

    // 4: two-cycle gap between write beats
    vals = '{16'h1234, 16'h5678, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    do_write(3, 1, vals, 0, 2, cycles);
    chk("t4_cycles", 32'(cycles), 32'd5);

    // 5: reset during the second beat of a len-3 read
    send_req(1'b0, 0, 3);
    bus.rdata_ready = 1'b1;
    #1;
    chk("t5_first_strobe", 32'(bus.sig_mem_read), 32'd1);
    cyc();
    rst = 1'b1;
    #1;
    chk("t5_rst_rd", 32'(bus.sig_mem_read), 32'd0);
    chk("t5_rst_wr", 32'(bus.sig_mem_write), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("t5_valid", 32'(bus.rdata_valid), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_resume", 32'(bus.sig_mem_read), 32'd0);
      cyc();
    end
    do_read(2, 0, 0, 0, cycles);
    chk("t5_ref_addr2", 32'(ref_mem[2]), 32'h0009);

    // Randomized bursts with backpressure and write gaps
    for (int t = 0; t < 24; t++) begin
      int a = $urandom_range(DEPTH - 1);
      int l = $urandom_range(7);
      if ($urandom_range(1) == 1) begin
        for (int i = 0; i < 8; i++) vals[i] = 16'($urandom);
        do_write(a, l, vals, 30, 0, cycles);
      end else begin
        do_read(a, l, 30, 0, cycles);
      end
    end

    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
